bcd_updown_counter_n: RTL
=========================

Name: bcd_updown_counter_n

Overview:
- Parametrised N-digit BCD counter; successor to the fixed 3-digit up-only decade counter.
- Adds up/down counting, synchronous clear and parallel load, wrap or saturate mode, and a sticky overflow flag.
- Provides a cascadable terminal-count output so several instances can be chained.
- Used by display/timer logic that needs a decimal count of configurable length.

Parameters:
- DIGITS, 3, number of BCD decades (1..8); count width is 4*DIGITS.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to 0; clears ovf.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in [3:0].
- en  in  1  count enable (the cascade input).
- up  in  1  1 = increment, 0 = decrement.
- sat  in  1  1 = saturate at 9..9 / 0..0; 0 = wrap.
- count  out  4*DIGITS  registered BCD value; digit 0 is in [3:0].
- tc  out  1  combinational terminal count, for cascading.
- ovf  out  1  registered sticky overflow/underflow flag.

Behaviour:
- Reset (reset_n=0, async): count=0, ovf=0, and load_err=0 when the optional feature is built. tc follows from the reset state: with en=1 and up=0 it reads 1, because all digits are 0.
- Per-cycle priority: clr > load > en. With en=0 and no clr/load, count holds.
- Up count:
  - digit i increments when en=1 and all digits below i are 9.
  - A digit at 9 goes to 0.
  - Digit 0 steps whenever en=1.
- Down count:
  - digit i decrements when en=1 and all digits below i are 0.
  - A digit at 0 goes to 9.
- tc = en & (up ? all digits==9 : all digits==0). Purely combinational; asserted during the cycle in which the wrap/saturate edge occurs.
- Wrap mode (sat=0), terminal value with en=1:
  - up at 9..9 goes to 0..0.
  - down at 0..0 goes to 9..9.
  - ovf sets on the next clock edge.
- Saturate mode (sat=0 not set, i.e. sat=1), terminal value with en=1:
  - count holds; tc still asserts.
  - ovf sets on the next clock edge.
- ovf stays 1 until clr or reset. A load does not clear ovf.
- A load taking effect in a cycle with tc=1 suppresses the ovf set, because load has priority.
- Changing up or sat mid-count takes effect on the next edge. No pipeline state exists, so latency from en to count change is 1 cycle.
- Load latency is 1 cycle; the loaded value appears on count the cycle after load=1.
- Without the optional feature, any load_val digit >9 is stored as 0; valid digits load unchanged.
- Reset asserted mid-operation overrides everything immediately (async).

Optional Feature:
- Macro BCD_LOAD_CHECK_EN.
- When defined:
  - adds output load_err (1 bit, registered).
  - a load with any digit >9 is rejected: count is unchanged.
  - load_err=1 on the following cycle, for exactly one cycle.
  - a valid load or no load gives load_err=0.
  - clr in the same cycle takes priority and load_err stays 0.
- When undefined: no load_err port; invalid digits are sanitised to 0 as described above.

Decomposition:
- Shared package bcd_pkg:
  - constant BCD_W=4
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0
  - typedef bcd_digit_t (logic [3:0])
- Sub-module bcd_digit. One per decade, instantiated in a generate loop. It has:
  - inputs: clk, reset_n, clr, load, d, step, up
  - outputs: q, is_max, is_min
- The top level computes the ripple step enables as an AND prefix of is_max/is_min, plus tc, saturation gating and ovf.

Test Plan (DIGITS=3):
- Reset: assert reset_n=0 mid-count at count=0x457 -> count=0x000 and ovf=0 asynchronously, before the next clk.
- Up wrap: load 0x998, up=1, sat=0, en=1 for 3 cycles:
  - count goes 0x999 then 0x000 then 0x001.
  - tc=1 only while count=0x999.
  - ovf=1 from the cycle count reads 0x000, and remains 1.
- Down borrow chain: load 0x100, up=0, en=1 -> count 0x099. Continue 99 more cycles -> 0x000, tc=1 at 0x000. One more cycle -> 0x999 with ovf=1.
- Saturate: load 0x999, sat=1, up=1, en=1 for 4 cycles -> count stays 0x999, tc=1 each cycle, ovf=1 after the first edge. Then clr=1 -> count=0x000, ovf=0.
- Priority: clr=1, load=1 (load_val=0x321) and en=1 in the same cycle -> count=0x000. Next cycle load=1 with en=1 -> count=0x321, not 0x322.
- Invalid load: load_val=0x3A5.
  - Without BCD_LOAD_CHECK_EN: count=0x305.
  - With it: count unchanged, and load_err pulses 1 for one cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD counter slice: digit width, the legal digit
// range and a helper that recognises a legal BCD digit.
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // True when the nibble encodes a decimal digit 0..9.
  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter. Steps up or down by one with wrap 9->0 and
// 0->9; the parent decides when a step is allowed.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (q -> 0)
//   clr      in   synchronous clear to 0 (highest priority)
//   load     in   synchronous load of d
//   d        in   digit value to load (already known to be 0..9)
//   step     in   advance this digit by one in the direction given by up
//   up       in   1 = increment, 0 = decrement
//   q        out  registered digit value
//   is_max   out  q == 9
//   is_min   out  q == 0
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t d,
  input  logic       step,
  input  logic       up,
  output bcd_digit_t q,
  output logic       is_max,
  output logic       is_min
);

  bcd_digit_t r_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= BCD_MIN;
    end else if (clr) begin
      r_q <= BCD_MIN;
    end else if (load) begin
      r_q <= d;
    end else if (step) begin
      if (up) begin
        r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
      end else begin
        r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
      end
    end
  end

  assign q      = r_q;
  assign is_max = (r_q == BCD_MAX);
  assign is_min = (r_q == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_updown_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_n
// DIGITS-decade BCD up/down counter with synchronous clear, parallel load,
// wrap or saturate at the terminal value, sticky overflow flag and a
// combinational terminal-count output for cascading.
//
// Parameters:
//   DIGITS    number of decades (1..8); count width is 4*DIGITS
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   clr       in   synchronous clear of count and ovf (beats load and en)
//   load      in   synchronous parallel load of load_val (beats en)
//   load_val  in   BCD load value, digit 0 in [3:0]
//   en        in   count enable / cascade input
//   up        in   1 = increment, 0 = decrement
//   sat       in   1 = hold at the terminal value, 0 = wrap
//   count     out  registered BCD count, digit 0 in [3:0]
//   tc        out  combinational terminal count (en and all 9s up / all 0s down)
//   ovf       out  registered sticky overflow/underflow flag
//   load_err  out  (BCD_LOAD_CHECK_EN only) one-cycle pulse after a rejected load
//
// Build option BCD_LOAD_CHECK_EN: loads containing a digit >9 are rejected
// (count unchanged) and flagged on load_err. Without it, such digits are
// stored as 0 and the legal digits load normally.
// -----------------------------------------------------------------------------
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                  en,
  input  logic                  up,
  input  logic                  sat,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                  tc,
  output logic                  ovf
`ifdef BCD_LOAD_CHECK_EN
  ,
  output logic                  load_err
`endif
);

  localparam int W = BCD_W * DIGITS;

  logic [DIGITS-1:0] w_is_max;
  logic [DIGITS-1:0] w_is_min;
  logic [DIGITS-1:0] w_carry_in;   // en AND all lower digits at their limit
  logic [DIGITS-1:0] w_step;
  logic              w_tc;
  logic              w_any_bad;
  logic [W-1:0]      w_load_val;   // load_val with illegal digits forced to 0
  logic              w_digit_load;
  logic              r_ovf;

  // Ripple enable: digit i moves only when every digit below it sits at the
  // limit for the current direction. The value rippled past the top digit is
  // the terminal count.
  // NOTE: every variable driven here gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic w_run;
    w_carry_in = '0;
    w_run      = en;
    for (int i = 0; i < DIGITS; i++) begin
      w_carry_in[i] = w_run;
      w_run         = w_run & (up ? w_is_max[i] : w_is_min[i]);
    end
    w_tc = w_run;
  end

  // Scan the load value for non-decimal nibbles and build a sanitised copy.
  always_comb begin
    w_any_bad  = 1'b0;
    w_load_val = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_is_valid(load_val[i*BCD_W +: BCD_W])) begin
        w_any_bad                     = 1'b1;
        w_load_val[i*BCD_W +: BCD_W]  = BCD_MIN;
      end
    end
  end

`ifdef BCD_LOAD_CHECK_EN
  // A bad load is dropped entirely; the step gating below still sees load=1,
  // so the count holds rather than falling through to the enable.
  assign w_digit_load = load & ~w_any_bad;
`else
  assign w_digit_load = load;
`endif

  // Load outranks counting; in saturate mode the terminal value is frozen.
  assign w_step = w_carry_in & {DIGITS{~load & ~(sat & w_tc)}};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .load    (w_digit_load),
      .d       (w_load_val[g*BCD_W +: BCD_W]),
      .step    (w_step[g]),
      .up      (up),
      .q       (count[g*BCD_W +: BCD_W]),
      .is_max  (w_is_max[g]),
      .is_min  (w_is_min[g])
    );
  end

  // Sticky overflow: set by a terminal-count edge in either mode, unless a
  // load owns that cycle; only clr or reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (!load && w_tc) begin
      r_ovf <= 1'b1;
    end
  end

  assign tc  = w_tc;
  assign ovf = r_ovf;

`ifdef BCD_LOAD_CHECK_EN
  logic r_load_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= ~clr & load & w_any_bad;
    end
  end

  assign load_err = r_load_err;
`endif

endmodule : bcd_updown_counter_n
